// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the HI/LO multiply-divide unit: operation codes, FSM states
// and the latency helper.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // state    | meaning
    // ST_IDLE  | waiting for start; mthi/mtlo complete here
    // ST_CALC  | one multiply/divide iteration (UNROLL bits) per cycle
    // ST_FIXUP | sign correction and HI/LO write
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } state_e;

    // Cycles from acceptance until the result is ready (CALC cycles plus FIXUP).
    function automatic int mdu_latency(input int width, input int unroll);
        return width / unroll + 1;
    endfunction

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    // rem_in < divisor keeps shifted below 2*divisor, so bit WIDTH of diff is the borrow
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply-divide unit: shift-add multiply and restoring divide on
// operand magnitudes, sign fix-up in a final cycle, single-cycle mthi/mtlo.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mdOp,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int STEPS = mdu_latency(WIDTH, UNROLL) - 1;
    localparam int CW    = $clog2(STEPS + 1);

    state_e                  state, state_nxt;
    logic [CW-1:0]           cnt;
    logic [WIDTH-1:0]        acc_hi, acc_lo, opb;
    logic                    op_div, neg_a, neg_b, dz;
    logic                    accept, is_mul, is_div, is_signed, neg1, neg2;
    logic                    calc_en, fix_en;
    logic [WIDTH-1:0]        abs1, abs2;
    logic [WIDTH:0]          mul_sum;
    logic [WIDTH-1:0]        mul_hi_nxt, mul_lo_nxt, div_rem_nxt, div_quo_nxt;
    logic [UNROLL:0][WIDTH-1:0] rem_chain;
    logic [UNROLL-1:0]       q_bits;
    logic [2*WIDTH-1:0]      prod_fix;
    logic [WIDTH-1:0]        quo_fix, rem_fix;

    assign is_mul    = (mdOp == OP_MULT) || (mdOp == OP_MULTU);
    assign is_div    = (mdOp == OP_DIV)  || (mdOp == OP_DIVU);
    assign is_signed = (mdOp == OP_MULT) || (mdOp == OP_DIV);
    assign neg1      = is_signed & din1[WIDTH-1];
    assign neg2      = is_signed & din2[WIDTH-1];
    assign abs1      = neg1 ? -din1 : din1;
    assign abs2      = neg2 ? -din2 : din2;
    assign accept    = start & ~busy & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (accept && (is_mul || is_div)) state_nxt = ST_CALC;
                ST_CALC:  if (cnt == CW'(1)) state_nxt = ST_FIXUP;
                ST_FIXUP: state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = 1'b0;
        calc_en = 1'b0;
        fix_en  = 1'b0;
        case (state)
            ST_CALC:  begin busy = 1'b1; calc_en = ~flush; end
            ST_FIXUP: begin busy = 1'b1; fix_en  = ~flush; end
            default:  ;
        endcase
    end

    // Shift-add: acc_lo holds the unconsumed multiplier bits, product bits shift in from the top.
    always_comb begin
        mul_sum    = '0;
        mul_hi_nxt = acc_hi;
        mul_lo_nxt = acc_lo;
        for (int i = 0; i < UNROLL; i++) begin
            mul_sum    = {1'b0, mul_hi_nxt} + (mul_lo_nxt[0] ? {1'b0, opb} : '0);
            mul_lo_nxt = {mul_sum[0], mul_lo_nxt[WIDTH-1:1]};
            mul_hi_nxt = mul_sum[WIDTH:1];
        end
    end

    assign rem_chain[0] = acc_hi;
    for (genvar g = 0; g < UNROLL; g++) begin : g_div
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_in (rem_chain[g]),
            .bit_in (acc_lo[WIDTH-1-g]),
            .divisor(opb),
            .rem_out(rem_chain[g+1]),
            .q_bit  (q_bits[UNROLL-1-g])
        );
    end
    assign div_rem_nxt = rem_chain[UNROLL];
    assign div_quo_nxt = {acc_lo[WIDTH-1-UNROLL:0], q_bits};

    assign prod_fix = (neg_a ^ neg_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo_fix  = dz ? '1 : ((neg_a ^ neg_b) ? -acc_lo : acc_lo);
    // A zero divisor leaves |din1| in the remainder, so the dividend-sign fix restores din1.
    assign rem_fix  = neg_a ? -acc_hi : acc_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opb       <= '0;
            op_div    <= 1'b0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            dz        <= 1'b0;
            divByZero <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (mdOp == OP_MTHI) begin
                    hi        <= din1;
                    done      <= 1'b1;
                    divByZero <= 1'b0;
                end else if (mdOp == OP_MTLO) begin
                    lo        <= din1;
                    done      <= 1'b1;
                    divByZero <= 1'b0;
                end else if (is_mul || is_div) begin
                    cnt       <= CW'(STEPS);
                    op_div    <= is_div;
                    neg_a     <= neg1;
                    neg_b     <= neg2;
                    dz        <= is_div && (din2 == '0);
                    divByZero <= is_div && (din2 == '0);
                    acc_hi    <= '0;
                    acc_lo    <= is_div ? abs1 : abs2;
                    opb       <= is_div ? abs2 : abs1;
                end
            end else if (calc_en) begin
                cnt    <= cnt - CW'(1);
                acc_hi <= op_div ? div_rem_nxt : mul_hi_nxt;
                acc_lo <= op_div ? div_quo_nxt : mul_lo_nxt;
            end else if (fix_en) begin
                done <= 1'b1;
                if (op_div) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end else begin
                    {hi, lo} <= prod_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: fixed vectors, random ops against an arithmetic model,
// and hand sequences for ignore/flush/reset; a second instance covers UNROLL=4.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, start_r = 1'b0, flush = 1'b0, use4 = 1'b0;
    logic [2:0]  mdOp = 3'd0;
    logic [31:0] din1 = '0, din2 = '0;
    logic        start1, start4;
    logic        busy1, done1, dz1, busy4, done4, dz4;
    logic [31:0] hi1, lo1, hi4, lo4;
    logic        c_busy, c_done, c_dz;
    logic [31:0] c_hi, c_lo;
    logic [31:0] m_hi = '0, m_lo = '0;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    assign start1 = start_r & ~use4;
    assign start4 = start_r &  use4;
    assign c_busy = use4 ? busy4 : busy1;
    assign c_done = use4 ? done4 : done1;
    assign c_dz   = use4 ? dz4   : dz1;
    assign c_hi   = use4 ? hi4   : hi1;
    assign c_lo   = use4 ? lo4   : lo1;

    mul_div_unit #(.WIDTH(32), .UNROLL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mdOp(mdOp), .din1(din1), .din2(din2),
        .flush(flush), .busy(busy1), .done(done1), .divByZero(dz1), .hi(hi1), .lo(lo1)
    );

    mul_div_unit #(.WIDTH(32), .UNROLL(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mdOp(mdOp), .din1(din1), .din2(din2),
        .flush(flush), .busy(busy4), .done(done4), .divByZero(dz4), .hi(hi4), .lo(lo4)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, e_hi, e_lo;
        logic        e_dz;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Architectural result straight from integer arithmetic.
    function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, b,
                                   output logic [31:0] h, l, output logic dz);
        longint      sa, sb, q, r;
        logic [63:0] p, t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = m_hi; l = m_lo; dz = 1'b0; p = '0; t = '0; q = 0; r = 0;
        case (op)
            3'd0: begin p = sa * sb; {h, l} = p; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; {h, l} = p; end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    h = a; l = '1; dz = 1'b1;
                end else if (op == 3'd2) begin
                    q = sa / sb; r = sa % sb;
                    p = q; t = r;
                    l = p[31:0]; h = t[31:0];
                end else begin
                    l = a / b; h = a % b;
                end
            end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endfunction

    // Called just after a negedge with the selected DUT idle; returns at the negedge where done is seen.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, b,
                         input logic [31:0] e_hi, e_lo, input logic e_dz, input string nm);
        int cyc, lat;
        bit muldiv;
        muldiv = (op < 3'd4);
        lat    = muldiv ? ((use4 ? 8 : 32) + 2) : 1;
        start_r = 1'b1; mdOp = op; din1 = a; din2 = b;
        @(negedge clk);
        start_r = 1'b0;
        cyc = 1;
        chk({nm, " divByZero@k+1"}, 64'(c_dz), 64'(e_dz));
        if (muldiv) chk({nm, " busy@k+1"}, 64'(c_busy), 64'd1);
        while (!c_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, " done cycle"}, 64'(cyc), 64'(lat));
        chk({nm, " hi"}, 64'(c_hi), 64'(e_hi));
        chk({nm, " lo"}, 64'(c_lo), 64'(e_lo));
        chk({nm, " busy@done"}, 64'(c_busy), 64'd0);
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b, eh, el;
        logic        ed;
        bit          seen;

        tbl[0]  = '{3'd0, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 1'b0};
        tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{3'd3, 32'h7,        32'h2,        32'h00000001, 32'h00000003, 1'b0};
        tbl[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[5]  = '{3'd3, 32'h1234,     32'h0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
        tbl[6]  = '{3'd1, 32'h12345678, 32'h0,        32'h00000000, 32'h00000000, 1'b0};
        tbl[7]  = '{3'd2, 32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        tbl[8]  = '{3'd2, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        tbl[9]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[10] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[11] = '{3'd3, 32'd1000,     32'd7,        32'd6,        32'd142,      1'b0};

        repeat (2) @(negedge clk);
        chk("reset busy",  64'(busy1), 64'd0);
        chk("reset done",  64'(done1), 64'd0);
        chk("reset dz",    64'(dz1),   64'd0);
        chk("reset hi",    64'(hi1),   64'd0);
        chk("reset lo",    64'(lo1),   64'd0);
        chk("reset busy4", 64'(busy4), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++)
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e_hi, tbl[i].e_lo, tbl[i].e_dz,
                  $sformatf("vec%0d", i));

        // mthi then mtlo on consecutive cycles
        start_r = 1'b1; mdOp = OP_MTHI; din1 = 32'h12345678;
        @(negedge clk);
        chk("mthi done", 64'(done1), 64'd1);
        chk("mthi hi",   64'(hi1),   64'h12345678);
        chk("mthi busy", 64'(busy1), 64'd0);
        mdOp = OP_MTLO; din1 = 32'h9ABCDEF0;
        @(negedge clk);
        start_r = 1'b0;
        chk("mtlo done", 64'(done1), 64'd1);
        chk("mtlo lo",   64'(lo1),   64'h9ABCDEF0);
        chk("mtlo hi",   64'(hi1),   64'h12345678);
        chk("mtlo busy", 64'(busy1), 64'd0);
        m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;

        // reserved op code does nothing
        start_r = 1'b1; mdOp = 3'd6; din1 = 32'hDEAD; din2 = 32'h3;
        @(negedge clk);
        start_r = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done1 || busy1) seen = 1'b1;
            @(negedge clk);
        end
        chk("noop activity", 64'(seen), 64'd0);
        chk("noop hi", 64'(hi1), 64'(m_hi));
        chk("noop lo", 64'(lo1), 64'(m_lo));

        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: a = 32'($urandom_range(0, 100));
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            ref_md(op, a, b, eh, el, ed);
            do_op(op, a, b, eh, el, ed, $sformatf("rand%0d", i));
        end

        // start ignored while busy, then flush mid-divide
        start_r = 1'b1; mdOp = OP_DIV; din1 = 32'd100; din2 = 32'd7;
        @(negedge clk);
        start_r = 1'b0;
        repeat (4) @(negedge clk);
        start_r = 1'b1; mdOp = OP_MTHI; din1 = 32'hDEADBEEF;
        @(negedge clk);
        start_r = 1'b0;
        chk("ignored start busy", 64'(busy1), 64'd1);
        chk("ignored start hi",   64'(hi1),   64'(m_hi));
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", 64'(busy1), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done1 || busy1) seen = 1'b1;
            @(negedge clk);
        end
        chk("flush no done", 64'(seen), 64'd0);
        chk("flush hi", 64'(hi1), 64'(m_hi));
        chk("flush lo", 64'(lo1), 64'(m_lo));

        // flush beats a simultaneous start
        start_r = 1'b1; flush = 1'b1; mdOp = OP_MTHI; din1 = 32'hCAFEF00D;
        @(negedge clk);
        start_r = 1'b0; flush = 1'b0;
        chk("flush+start done", 64'(done1), 64'd0);
        chk("flush+start hi",   64'(hi1),   64'(m_hi));

        // reset in the middle of a multiply
        do_op(OP_MTHI, 32'hA5A5A5A5, 32'd0, 32'hA5A5A5A5, m_lo, 1'b0, "pre-reset mthi");
        start_r = 1'b1; mdOp = OP_MULT; din1 = 32'h1234; din2 = 32'h5678;
        @(negedge clk);
        start_r = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", 64'(busy1), 64'd0);
        chk("midreset done", 64'(done1), 64'd0);
        chk("midreset dz",   64'(dz1),   64'd0);
        chk("midreset hi",   64'(hi1),   64'd0);
        chk("midreset lo",   64'(lo1),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0;
        @(negedge clk);

        // UNROLL=4 instance
        use4 = 1'b1;
        do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "u4 multu");
        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 5 == 0) ? 32'd0 : $urandom;
            ref_md(op, a, b, eh, el, ed);
            do_op(op, a, b, eh, el, ed, $sformatf("u4 rand%0d", i));
        end
        use4 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
